// File: rtl/cpu_pkg.sv
// Shared definitions for the next-PC sequencer: default sizes, run/halt
// state encoding and the next-PC source select.
package cpu_pkg;

    localparam int         DEF_AW        = 8;
    localparam int         DEF_DEPTH     = 4;
    localparam logic [7:0] DEF_TRAP_ADDR = 8'hF0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_RET  = 3'd1,
        SEL_CALL = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_BR   = 3'd4,
        SEL_INC  = 3'd5,
        SEL_TRAP = 3'd6
    } sel_t;

endpackage

// File: rtl/ras_stack.sv
// DEPTH-entry return-address LIFO. Push and pop are ignored when full or
// empty respectively; the caller decides what misuse means.
module ras_stack
    import cpu_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH,
    localparam int IW   = $clog2(DEPTH),
    localparam int DW   = IW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] depth
);

    logic [AW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_sp;
    logic [IW-1:0] w_sp_lo;
    logic [IW-1:0] w_top_idx;

    assign w_sp_lo   = r_sp[IW-1:0];
    assign w_top_idx = w_sp_lo - 1'b1;
    assign full      = (r_sp == DW'(DEPTH));
    assign empty     = (r_sp == '0);
    assign depth     = r_sp;
    assign top       = r_mem[w_top_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            // Push has precedence only in the unlikely case both arrive.
            if (push && !full) begin
                r_mem[w_sp_lo] <= din;
                r_sp           <= r_sp + 1'b1;
            end else if (pop && !empty) begin
                r_sp <= r_sp - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC generator: priority mux over hold/ret/call/jump/branch/increment,
// return-address stack with sticky misuse trap, and a run/halt FSM.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int            AW        = DEF_AW,
    parameter int            DEPTH     = DEF_DEPTH,
    parameter logic [AW-1:0] TRAP_ADDR = AW'(DEF_TRAP_ADDR)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [AW-1:0]            pc_cur,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [AW-1:0]            branch_target,
    input  logic                     jump,
    input  logic                     call,
    input  logic [AW-1:0]            jump_target,
    input  logic                     ret,
    input  logic                     halt,
    input  logic                     resume,
    output logic [AW-1:0]            pc_next,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   stack_depth,
    output logic                     stack_err
);

    state_t                   r_state;
    logic                     r_err;
    sel_t                     w_sel;
    logic [AW-1:0]            w_inc;
    logic [AW-1:0]            w_top;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [$clog2(DEPTH):0]   w_depth;

    assign w_inc = pc_cur + 1'b1;

    // Priority decode; misuse of the stack turns into a trap select.
    always_comb begin
        w_sel = SEL_INC;
        if (r_state == HALT || stall) begin
            w_sel = SEL_HOLD;
        end else if (ret) begin
            w_sel = w_empty ? SEL_TRAP : SEL_RET;
        end else if (call) begin
            w_sel = w_full ? SEL_TRAP : SEL_CALL;
        end else if (jump) begin
            w_sel = SEL_JMP;
        end else if (branch_taken) begin
            w_sel = SEL_BR;
        end
    end

    always_comb begin
        pc_next = w_inc;
        case (w_sel)
            SEL_HOLD: pc_next = pc_cur;
            SEL_RET:  pc_next = w_top;
            SEL_CALL: pc_next = jump_target;
            SEL_JMP:  pc_next = jump_target;
            SEL_BR:   pc_next = branch_target;
            SEL_TRAP: pc_next = TRAP_ADDR;
            default:  pc_next = w_inc;
        endcase
    end

    assign w_push = (w_sel == SEL_CALL);
    assign w_pop  = (w_sel == SEL_RET);

    ras_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ras (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_inc),
        .top   (w_top),
        .full  (w_full),
        .empty (w_empty),
        .depth (w_depth)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_err   <= 1'b0;
        end else begin
            if (w_sel == SEL_TRAP) begin
                r_err <= 1'b1;
            end
            case (r_state)
                RUN:     if (halt && !stall) r_state <= HALT;
                HALT:    if (resume)         r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    assign halted      = (r_state == HALT);
    assign stack_err   = r_err;
    assign stack_depth = w_depth;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: expected next-PC values queued as
// stimulus is applied, compared on the falling edge.
module tb_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pc_cur = 8'h10;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       jump = 1'b0;
    logic       call = 1'b0;
    logic [7:0] jump_target = 8'h00;
    logic       ret = 1'b0;
    logic       halt = 1'b0;
    logic       resume = 1'b0;
    logic [7:0] pc_next;
    logic       halted;
    logic [2:0] stack_depth;
    logic       stack_err;

    logic [7:0] exp_q[$];
    logic [7:0] push_pcs[4];
    logic [7:0] ret_addrs[4];
    int total = 0;
    int bad   = 0;

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .call          (call),
        .jump_target   (jump_target),
        .ret           (ret),
        .halt          (halt),
        .resume        (resume),
        .pc_next       (pc_next),
        .halted        (halted),
        .stack_depth   (stack_depth),
        .stack_err     (stack_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; call = 1'b0;
        ret = 1'b0; halt = 1'b0; resume = 1'b0;
    endtask

    // Queue the expected pc_next for the inputs now applied, compare it
    // mid-cycle, then let the clock edge commit the cycle.
    task automatic step(input string tag, input logic [7:0] exp_pc);
        logic [7:0] e;
        exp_q.push_back(exp_pc);
        @(negedge clock);
        e = exp_q.pop_front();
        check(tag, pc_next, e);
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        // Reset state, no clock edge yet
        #3;
        check("rst_pc", pc_next, 8'h11);
        check("rst_halted", halted, 1'b0);
        check("rst_depth", stack_depth, 3'd0);
        check("rst_err", stack_err, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) step("idle_pc", 8'h11);
        check("idle_halted", halted, 1'b0);
        check("idle_depth", stack_depth, 3'd0);

        // Increment wrap, stall priority, branch, jump
        pc_cur = 8'hFF;
        step("wrap_inc", 8'h00);
        pc_cur = 8'hFF; stall = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        step("stall_br", 8'hFF);
        pc_cur = 8'h10; branch_taken = 1'b1; branch_target = 8'h40;
        step("branch", 8'h40);
        pc_cur = 8'h40; jump = 1'b1; jump_target = 8'h66; branch_taken = 1'b1;
        step("jump_over_br", 8'h66);
        pc_cur = 8'h20; stall = 1'b1; call = 1'b1; jump_target = 8'h80;
        step("stall_call", 8'h20);
        check("stall_no_push", stack_depth, 3'd0);

        // Single call/return
        pc_cur = 8'h20; call = 1'b1; jump_target = 8'h80;
        step("call", 8'h80);
        check("call_depth", stack_depth, 3'd1);
        pc_cur = 8'h85; ret = 1'b1;
        step("ret", 8'h21);
        check("ret_depth", stack_depth, 3'd0);

        // Fill, overflow, drain in LIFO order, underflow
        push_pcs  = '{8'hFF, 8'h41, 8'h52, 8'h63};
        ret_addrs = '{8'h00, 8'h42, 8'h53, 8'h64};
        for (int i = 0; i < 4; i++) begin
            pc_cur = push_pcs[i]; call = 1'b1; jump_target = 8'h80 + 8'(i);
            step("fill_call", 8'h80 + 8'(i));
        end
        check("full_depth", stack_depth, 3'd4);
        check("full_noerr", stack_err, 1'b0);
        pc_cur = 8'h70; call = 1'b1; jump_target = 8'h90;
        step("ovf_trap", 8'hF0);
        check("ovf_err", stack_err, 1'b1);
        check("ovf_depth", stack_depth, 3'd4);
        for (int i = 3; i >= 0; i--) begin
            pc_cur = 8'hA0; ret = 1'b1;
            step("lifo_ret", ret_addrs[i]);
        end
        check("drain_depth", stack_depth, 3'd0);
        pc_cur = 8'hA0; ret = 1'b1;
        step("unf_trap", 8'hF0);
        check("unf_depth", stack_depth, 3'd0);
        check("err_sticky", stack_err, 1'b1);

        // ret beats call and jump in the same cycle
        pc_cur = 8'h32; call = 1'b1; jump_target = 8'h70;
        step("call_33", 8'h70);
        pc_cur = 8'h77; ret = 1'b1; call = 1'b1; jump = 1'b1; jump_target = 8'h55;
        step("ret_wins", 8'h33);
        check("ret_wins_depth", stack_depth, 3'd0);

        // Halt with a jump, ignored controls while halted, resume
        pc_cur = 8'h10; halt = 1'b1; jump = 1'b1; jump_target = 8'h50;
        step("halt_jump", 8'h50);
        check("halted_set", halted, 1'b1);
        pc_cur = 8'h50; jump = 1'b1; call = 1'b1; jump_target = 8'h60;
        step("halt_hold", 8'h50);
        check("halt_no_push", stack_depth, 3'd0);
        pc_cur = 8'h50; resume = 1'b1;
        step("resume_hold", 8'h50);
        check("resumed", halted, 1'b0);
        pc_cur = 8'h50; resume = 1'b1;
        step("resume_run", 8'h51);
        check("run_stays", halted, 1'b0);
        pc_cur = 8'h51; halt = 1'b1; stall = 1'b1;
        step("halt_stalled", 8'h51);
        check("halt_stall_ign", halted, 1'b0);

        // Async reset while halted with two entries
        pc_cur = 8'h01; call = 1'b1; jump_target = 8'h11;
        step("pre_call1", 8'h11);
        pc_cur = 8'h11; call = 1'b1; jump_target = 8'h22; halt = 1'b1;
        step("pre_call2", 8'h22);
        check("pre_depth", stack_depth, 3'd2);
        check("pre_halted", halted, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_halted", halted, 1'b0);
        check("arst_depth", stack_depth, 3'd0);
        check("arst_err", stack_err, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;

        // Stalled ret on empty stack must not trap; unstalled one does
        pc_cur = 8'h44; ret = 1'b1; stall = 1'b1;
        step("stall_ret", 8'h44);
        check("stall_noerr", stack_err, 1'b0);
        pc_cur = 8'h44; ret = 1'b1;
        step("post_rst_unf", 8'hF0);
        check("post_rst_err", stack_err, 1'b1);

        if (exp_q.size() != 0) check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC generator sitting directly upstream of the 8-bit program-counter register; its pc_next output drives the register's pcin, and the register's pcout is fed back as pc_cur.
- Selects between sequential increment, branch, jump, call and return targets.
- Owns a small hardware return-address stack and a run/halt state machine.
- Flags stack misuse with a trap redirect.

Parameters:
- AW, 8, address width; matches the PC register width.
- DEPTH, 4, return-stack entries; power of two, 2..16.
- TRAP_ADDR, 8'hF0, vector taken on stack overflow or underflow.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately, independent of clock.
- pc_cur  in  AW  current PC, fed back from the PC register output.
- stall  in  1  hold PC; no stack or state change this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_target  in  AW  branch destination.
- jump  in  1  unconditional jump.
- call  in  1  call: jump to jump_target and push pc_cur+1.
- jump_target  in  AW  destination for jump and call.
- ret  in  1  return: pop the stack top into pc_next.
- halt  in  1  enter HALT.
- resume  in  1  leave HALT.
- pc_next  out  AW  combinational next PC, drives the PC register's pcin.
- halted  out  1  registered; 1 while in HALT.
- stack_depth  out  $clog2(DEPTH)+1  registered count of valid entries.
- stack_err  out  1  registered, sticky; set on overflow or underflow.

Behaviour:
- Reset (reset=0): sp=0, all stack entries 0, state=RUN, halted=0, stack_err=0, stack_depth=0. pc_next then evaluates combinationally as pc_cur+1.
- States:
  - RUN -> HALT when halt=1 and stall=0 (takes effect next cycle).
  - HALT -> RUN when resume=1.
  - halt is ignored in HALT; resume is ignored in RUN.
  - In HALT: pc_next=pc_cur, and all other control inputs are ignored.
- Priority in RUN, evaluated the same cycle (combinational path to pc_next, zero latency):
  1. stall: pc_next=pc_cur.
  2. ret.
  3. call.
  4. jump: pc_next=jump_target.
  5. branch_taken: pc_next=branch_target.
  6. Otherwise: pc_next=pc_cur+1.
  - Lower-priority requests asserted in the same cycle are dropped, not queued.
- halt asserted with a control request in the same non-stalled cycle: the request is executed this cycle, then HALT is entered.
- Increment arithmetic is modulo 2^AW: pc_cur=8'hFF gives pc_next=8'h00. The same applies to the pushed call return address.
- call:
  - Stack not full: push pc_cur+1 at sp, sp+1 on clock, pc_next=jump_target.
  - Stack full (depth==DEPTH): no push, stack_err<=1, pc_next=TRAP_ADDR.
- ret:
  - Stack not empty: pc_next=stack[sp-1], sp-1 on clock.
  - Stack empty: sp unchanged, stack_err<=1, pc_next=TRAP_ADDR.
- call and ret in the same cycle: ret wins; no push occurs.
- stack_err clears only on reset. Further errors re-vector to TRAP_ADDR each time.
- stall=1 suppresses the stack update, the error flag update and the halt transition for that cycle.
- Reset mid-operation (any state, any depth): immediate return to reset values; stack contents are zeroed.

Decomposition:
- Shared package (cpu_pkg):
  - AW, DEPTH and TRAP_ADDR defaults.
  - The state encoding: RUN=1'b0, HALT=1'b1.
  - The next-PC source select encoding: SEL_HOLD, SEL_RET, SEL_CALL, SEL_JMP, SEL_BR, SEL_INC, SEL_TRAP.
- One sub-module: ras_stack, holding the DEPTH-entry LIFO.
  - Inputs: push, pop, din.
  - Outputs: top, full, empty, depth.
  - Async active-low reset on the same clock and reset.
- pc_sequencer keeps the priority mux and the state machine.

Test Plan:
- Reset low with pc_cur=8'h10 -> pc_next=8'h11, halted=0, stack_depth=0, stack_err=0; release reset, 4 idle cycles -> values unchanged.
- pc_cur=8'hFF, no controls -> pc_next=8'h00; stall=1 with branch_taken=1, branch_target=8'h40 -> pc_next=8'hFF.
- call, pc_cur=8'h20, jump_target=8'h80 -> pc_next=8'h80, depth=1 next cycle; then ret with pc_cur=8'h85 -> pc_next=8'h21, depth=0.
- 4 calls fill the stack; 5th call with jump_target=8'h90 -> pc_next=8'hF0, stack_err=1, depth stays 4; then 4 rets return the pushed addresses in LIFO order; 5th ret -> 8'hF0.
- Same cycle ret+call+jump with stack top 8'h33 -> pc_next=8'h33, depth decrements, no push.
- halt with jump_target=8'h50, jump=1 -> pc_next=8'h50, halted=1 next cycle, pc_next=pc_cur while halted; resume -> halted=0; reset asserted while halted with depth=2 -> halted=0, depth=0 immediately.
